wishbone_cmd_master: RTL and testbench

Wishbone B3 master engine that turns host-side commands into single or incrementing-burst bus cycles toward the board's control-register slave (SPI, trigger/ack, JTAG-select registers). It sits between the PCI-side command logic and the shared Wishbone bus. It drives cyc/stb, handles ack/err/rty, enforces a no-response timeout, streams write data in and read data out, and reports a per-command completion status.

---
 rtl/wishbone_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_wishbone_cmd_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_cmd_master
// Purpose  : Wishbone B3 master engine. Turns host commands into single or
//            incrementing-burst bus cycles. Handles ack/err/rty responses and
//            aborts on a no-response timeout. Streams write data in, read data
//            out, and reports a completion status per command.
// Ports    : clk_i/reset_i       clock, synchronous active-high reset
//            cmd_*               command handshake and fields (we/adr/sel/len)
//            wr_dat_i/wr_valid_i/wr_ready_o   write-data stream
//            rd_dat_o/rd_valid_o read-data stream (no backpressure)
//            done_o/status_o     completion pulse and held status
//                                (00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_FAIL)
//            cyc_o..bte_o, dat_i, ack_i/err_i/rty_i   Wishbone master side
// Config   : define WB_MASTER_BURST_EN to honour cmd_len_i, producing
//            incrementing bursts (cti 010, last beat 111). Without it every
//            command is a single classic cycle.
// Revision : 1.0  initial release
// ============================================================================
module wishbone_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [3:0]  cmd_len_i,
    input  logic [31:0] wr_dat_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    output logic [31:0] rd_dat_o,
    output logic        rd_valid_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BEAT      = 2'd1,
        S_RETRY_GAP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [2:0] c_cti_classic = 3'b000;
    localparam logic [2:0] c_cti_incr    = 3'b010;
    localparam logic [2:0] c_cti_end     = 3'b111;

    localparam logic [1:0] c_st_ok    = 2'b00;
    localparam logic [1:0] c_st_err   = 2'b01;
    localparam logic [1:0] c_st_tmo   = 2'b10;
    localparam logic [1:0] c_st_rtyf  = 2'b11;

    // Last value the counters may hold before the abort condition fires.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_rty_last = 8'(MAX_RETRIES - 1);

`ifdef WB_MASTER_BURST_EN
    localparam bit c_burst_en = 1'b1;
`else
    localparam bit c_burst_en = 1'b0;
`endif

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_tmo;
    logic [7:0]  r_rty;

    logic [3:0]  w_len;
    logic        w_ack;
    logic        w_err;
    logic        w_rty;
    logic        w_unused;

    assign w_len    = c_burst_en ? cmd_len_i : 4'd0;
    assign w_unused = ^cmd_adr_i[1:0];

    // Writes only strobe while the host has data ready, so a stalled write
    // presents no request to the slave.
    assign stb_o = (r_state == S_BEAT) && (!we_o || wr_valid_i);
    assign dat_o = ((r_state == S_BEAT) && we_o) ? wr_dat_i : 32'h0;
    assign bte_o = 2'b00;

    assign cmd_ready_o = (r_state == S_IDLE);

    // Response priority: err > rty > ack.
    assign w_err = stb_o && err_i;
    assign w_rty = stb_o && !err_i && rty_i;
    assign w_ack = stb_o && !err_i && !rty_i && ack_i;

    assign wr_ready_o = w_ack && we_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_tmo      <= 8'd0;
            r_rty      <= 8'd0;
            cyc_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= 32'h0;
            sel_o      <= 4'h0;
            cti_o      <= c_cti_classic;
            rd_dat_o   <= 32'h0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            status_o   <= c_st_ok;
        end else begin
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_state <= S_BEAT;
                        cyc_o   <= 1'b1;
                        we_o    <= cmd_we_i;
                        adr_o   <= {cmd_adr_i[31:2], 2'b00};
                        sel_o   <= cmd_sel_i;
                        r_cnt   <= w_len;
                        r_tmo   <= 8'd0;
                        r_rty   <= 8'd0;
                        cti_o   <= (w_len != 4'd0) ? c_cti_incr : c_cti_classic;
                    end
                end
                S_BEAT: begin
                    if (w_err) begin
                        r_state  <= S_DONE;
                        cyc_o    <= 1'b0;
                        done_o   <= 1'b1;
                        status_o <= c_st_err;
                    end else if (w_rty) begin
                        r_tmo <= 8'd0;
                        if (r_rty == c_rty_last) begin
                            r_state  <= S_DONE;
                            cyc_o    <= 1'b0;
                            done_o   <= 1'b1;
                            status_o <= c_st_rtyf;
                        end else begin
                            r_rty   <= r_rty + 8'd1;
                            r_state <= S_RETRY_GAP;
                        end
                    end else if (w_ack) begin
                        if (!we_o) begin
                            rd_valid_o <= 1'b1;
                            rd_dat_o   <= dat_i;
                        end
                        adr_o <= adr_o + 32'd4;
                        r_tmo <= 8'd0;
                        r_rty <= 8'd0;
                        if (r_cnt == 4'd0) begin
                            r_state  <= S_DONE;
                            cyc_o    <= 1'b0;
                            done_o   <= 1'b1;
                            status_o <= c_st_ok;
                        end else begin
                            // stb stays high: next beat goes out with no wait state.
                            r_cnt <= r_cnt - 4'd1;
                            if (r_cnt == 4'd1 && cti_o == c_cti_incr) begin
                                cti_o <= c_cti_end;
                            end
                        end
                    end else if (stb_o) begin
                        if (r_tmo == c_tmo_last) begin
                            r_state  <= S_DONE;
                            cyc_o    <= 1'b0;
                            done_o   <= 1'b1;
                            status_o <= c_st_tmo;
                        end else begin
                            r_tmo <= r_tmo + 8'd1;
                        end
                    end
                end
                S_RETRY_GAP: begin
                    r_state <= S_BEAT;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wishbone_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_cmd_master
// Purpose  : Self-checking bench for wishbone_cmd_master. Directed commands
//            push expected read data and completion status into scoreboard
//            queues; a monitor pops and compares whenever rd_valid_o or done_o
//            fires. A scripted slave answers each strobed cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_wishbone_cmd_master;

    localparam logic [2:0] R_NONE   = 3'b000;
    localparam logic [2:0] R_ACK    = 3'b001;
    localparam logic [2:0] R_RTY    = 3'b010;
    localparam logic [2:0] R_RTYACK = 3'b011;
    localparam logic [2:0] R_ERR    = 3'b100;
    localparam logic [2:0] R_ALL    = 3'b111;

    logic        clk_i;
    logic        reset_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [3:0]  cmd_sel_i, cmd_len_i;
    logic [31:0] wr_dat_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] rd_dat_o;
    logic        rd_valid_o, done_o;
    logic [1:0]  status_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    wishbone_cmd_master #(.TIMEOUT_CYCLES(255), .MAX_RETRIES(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_len_i(cmd_len_i),
        .wr_dat_i(wr_dat_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .cti_o(cti_o), .bte_o(bte_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Scoreboard and slave scripts
    logic [31:0] exp_rd[$];
    logic [1:0]  exp_done[$];
    logic [2:0]  resp_q[$];
    logic [31:0] rdat_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] adr_tr[$];
    logic [31:0] dat_tr[$];
    logic [2:0]  cti_tr[$];
    logic [3:0]  sel_tr[$];
    logic        we_tr[$];
    int          stb_cnt, wrrdy_cnt, stall_cycles;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares DUT output events against the scoreboard queues.
    always @(negedge clk_i) begin
        if (rd_valid_o) begin
            if (exp_rd.size() == 0) check("rd_unexpected", {31'd0, rd_valid_o}, 32'd0);
            else check("rd_dat", rd_dat_o, exp_rd.pop_front());
        end
        if (done_o) begin
            if (exp_done.size() == 0) check("done_unexpected", {31'd0, done_o}, 32'd0);
            else check("status", {30'd0, status_o}, {30'd0, exp_done.pop_front()});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_test();
        resp_q.delete(); rdat_q.delete(); wr_q.delete();
        adr_tr.delete(); dat_tr.delete(); cti_tr.delete(); sel_tr.delete(); we_tr.delete();
        stall_cycles = 0;
        wr_valid_i   = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [3:0] len);
        @(negedge clk_i);
        check("cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_sel_i   = sel;
        cmd_len_i   = len;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    // Scripted slave: one script entry is consumed per strobed cycle.
    task automatic run_bus(input int bound, output bit got_done, output int n_cyc);
        logic [2:0] r;
        got_done  = 1'b0;
        n_cyc     = bound;
        stb_cnt   = 0;
        wrrdy_cnt = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk_i);
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
            if (done_o) begin
                got_done = 1'b1;
                n_cyc    = c;
                break;
            end
            wr_valid_i = (stall_cycles == 0) && (wr_q.size() > 0);
            if (stall_cycles > 0) stall_cycles--;
            if (wr_q.size() > 0) wr_dat_i = wr_q[0];
            else wr_dat_i = 32'h0;
            #1;
            if (stb_o) begin
                stb_cnt++;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else r = R_NONE;
                {err_i, rty_i, ack_i} = r;
                if (r == R_ACK) begin
                    if (rdat_q.size() > 0) dat_i = rdat_q.pop_front();
                    else dat_i = 32'h0;
                    adr_tr.push_back(adr_o);
                    dat_tr.push_back(dat_o);
                    cti_tr.push_back(cti_o);
                    sel_tr.push_back(sel_o);
                    we_tr.push_back(we_o);
                end
                #1;
                if (wr_ready_o) begin
                    wrrdy_cnt++;
                    if (wr_q.size() > 0) void'(wr_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        bit got;
        int nc;
        reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 32'h0;
        cmd_sel_i = 4'h0; cmd_len_i = 4'h0; wr_dat_i = 32'h0; wr_valid_i = 1'b0;
        dat_i = 32'h0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        clear_test();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ctrl", {27'd0, cyc_o, stb_o, we_o, wr_ready_o, rd_valid_o}, 32'd0);
        check("rst_ready_done_status", {28'd0, cmd_ready_o, done_o, status_o}, 32'h8);
        check("rst_adr_dat", adr_o | dat_o | rd_dat_o, 32'h0);
        check("rst_sel_cti_bte", {23'd0, sel_o, cti_o, bte_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Single read, ack one cycle after stb rises
        clear_test();
        resp_q = '{R_NONE, R_ACK};
        rdat_q = '{32'hDEADBEEF};
        exp_rd.push_back(32'hDEADBEEF);
        exp_done.push_back(2'b00);
        issue(1'b0, 32'h4, 4'hF, 4'd0);
        run_bus(20, got, nc);
        check("rd1_done", {31'd0, got}, 32'd1);
        check("rd1_done_cycle", nc, 32'd2);
        check("rd1_cyc_low", {30'd0, cyc_o, stb_o}, 32'd0);
        check("rd1_adr", adr_tr[0], 32'h4);
        check("rd1_cti", {29'd0, cti_tr[0]}, 32'd0);

        // Single write
        clear_test();
        resp_q = '{R_ACK};
        wr_q   = '{32'hA5A50003};
        exp_done.push_back(2'b00);
        issue(1'b1, 32'h8, 4'b0001, 4'd0);
        run_bus(20, got, nc);
        check("wr1_done", {31'd0, got}, 32'd1);
        check("wr1_dat", dat_tr[0], 32'hA5A50003);
        check("wr1_sel_we_adr", {27'd0, sel_tr[0], we_tr[0]}, 32'h3);
        check("wr1_adr", adr_tr[0], 32'h8);
        check("wr1_wr_ready", wrrdy_cnt, 32'd1);

        // Write stalled longer than the timeout on wr_valid_i: must still
        // complete OK; unaligned address bits are dropped.
        clear_test();
        resp_q = '{R_ACK};
        wr_q   = '{32'h0BADF00D};
        stall_cycles = 260;
        exp_done.push_back(2'b00);
        issue(1'b1, 32'h13, 4'hF, 4'd0);
        run_bus(400, got, nc);
        check("stall_done", {31'd0, got}, 32'd1);
        check("stall_stb_cycles", stb_cnt, 32'd1);
        check("stall_adr", adr_tr[0], 32'h10);
        check("stall_wr_ready", wrrdy_cnt, 32'd1);

        // err_i aborts a write
        clear_test();
        wr_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        exp_done.push_back(2'b01);
`ifdef WB_MASTER_BURST_EN
        resp_q = '{R_ACK, R_ERR};
        issue(1'b1, 32'h20, 4'hF, 4'd3);
        run_bus(20, got, nc);
        check("err_wr_ready", wrrdy_cnt, 32'd1);
        check("err_left", wr_q.size(), 32'd3);
        check("err_done_cycle", nc, 32'd2);
`else
        resp_q = '{R_ERR};
        issue(1'b1, 32'h20, 4'hF, 4'd3);
        run_bus(20, got, nc);
        check("err_wr_ready", wrrdy_cnt, 32'd0);
        check("err_left", wr_q.size(), 32'd4);
        check("err_done_cycle", nc, 32'd1);
`endif
        check("err_done", {31'd0, got}, 32'd1);
        check("err_cyc_low", {31'd0, cyc_o}, 32'd0);

        // Three retries exhaust the budget; a gap cycle follows each non-final rty
        clear_test();
        resp_q = '{R_RTY, R_RTY, R_RTY};
        exp_done.push_back(2'b11);
        issue(1'b0, 32'h40, 4'hF, 4'd0);
        run_bus(30, got, nc);
        check("rtyf_done", {31'd0, got}, 32'd1);
        check("rtyf_stb_cycles", stb_cnt, 32'd3);
        check("rtyf_done_cycle", nc, 32'd5);

        // Two retries then ack: completes OK
        clear_test();
        resp_q = '{R_RTY, R_RTY, R_ACK};
        rdat_q = '{32'h12345678};
        exp_rd.push_back(32'h12345678);
        exp_done.push_back(2'b00);
        issue(1'b0, 32'h44, 4'hF, 4'd0);
        run_bus(30, got, nc);
        check("rty2_done", {31'd0, got}, 32'd1);
        check("rty2_done_cycle", nc, 32'd5);

        // Priority: all three responses -> ERR
        clear_test();
        resp_q = '{R_ALL};
        exp_done.push_back(2'b01);
        issue(1'b0, 32'h48, 4'hF, 4'd0);
        run_bus(20, got, nc);
        check("prio_all_done_cycle", nc, 32'd1);

        // Priority: rty+ack -> retry, then plain ack completes
        clear_test();
        resp_q = '{R_RTYACK, R_ACK};
        rdat_q = '{32'hCAFE0001};
        exp_rd.push_back(32'hCAFE0001);
        exp_done.push_back(2'b00);
        issue(1'b0, 32'h4C, 4'hF, 4'd0);
        run_bus(20, got, nc);
        check("prio_rtyack_stb", stb_cnt, 32'd2);
        check("prio_rtyack_done_cycle", nc, 32'd3);

`ifdef WB_MASTER_BURST_EN
        // Zero-wait burst read, len=3
        clear_test();
        resp_q = '{R_ACK, R_ACK, R_ACK, R_ACK};
        rdat_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        exp_rd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        exp_done.push_back(2'b00);
        issue(1'b0, 32'h0, 4'hF, 4'd3);
        check("burst_bte", {30'd0, bte_o}, 32'd0);
        run_bus(30, got, nc);
        check("burst_done_cycle", nc, 32'd4);
        check("burst_adr", {adr_tr[0][7:0], adr_tr[1][7:0], adr_tr[2][7:0], adr_tr[3][7:0]},
              32'h0004080C);
        check("burst_cti", {20'd0, cti_tr[0], cti_tr[1], cti_tr[2], cti_tr[3]}, 32'h497);

        // Burst write across the top of the address space wraps to zero
        clear_test();
        resp_q = '{R_ACK, R_ACK};
        wr_q   = '{32'hAAAA0000, 32'hBBBB1111};
        exp_done.push_back(2'b00);
        issue(1'b1, 32'hFFFFFFFC, 4'hF, 4'd1);
        run_bus(20, got, nc);
        check("wrap_adr0", adr_tr[0], 32'hFFFFFFFC);
        check("wrap_adr1", adr_tr[1], 32'h0);
        check("wrap_dat1", dat_tr[1], 32'hBBBB1111);
        check("wrap_cti", {26'd0, cti_tr[0], cti_tr[1]}, 32'h17);
        check("wrap_wr_ready", wrrdy_cnt, 32'd2);
`else
        // len ignored: one classic beat
        clear_test();
        resp_q = '{R_ACK, R_ACK};
        rdat_q = '{32'h11111111, 32'h22222222};
        exp_rd.push_back(32'h11111111);
        exp_done.push_back(2'b00);
        issue(1'b0, 32'h0, 4'hF, 4'd3);
        run_bus(30, got, nc);
        check("nolen_done_cycle", nc, 32'd1);
        check("nolen_cti", {29'd0, cti_tr[0]}, 32'd0);
`endif

        // Timeout: no response at all
        clear_test();
        exp_done.push_back(2'b10);
        issue(1'b0, 32'h80, 4'hF, 4'd0);
        run_bus(300, got, nc);
        check("tmo_done", {31'd0, got}, 32'd1);
        check("tmo_stb_cycles", stb_cnt, 32'd255);

        // Repeat, then reset at cycle 100: no done, outputs back to reset
        clear_test();
        issue(1'b0, 32'h80, 4'hF, 4'd0);
        run_bus(100, got, nc);
        check("rstmid_no_done", {31'd0, got}, 32'd0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rstmid_ctrl", {28'd0, cyc_o, stb_o, done_o, cmd_ready_o}, 32'd1);
        check("rstmid_status", {30'd0, status_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rstmid_idle", {30'd0, cyc_o, done_o}, 32'd0);

        check("sb_rd_drained", exp_rd.size(), 32'd0);
        check("sb_done_drained", exp_done.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
